sap_ram: RTL and testbench

SAP_RAM -- requirements
Module: sap_ram

---
 rtl/sap_pkg.sv | 14 +
 rtl/ram_loader_fsm.sv | 85 ++++++++
 rtl/sap_ram.sv | 65 ++++++
 tb/tb_sap_ram.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared defaults and loader state encoding for the SAP RAM block.
package sap_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        RUN  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_loader_fsm.sv
// Program-load controller: tracks mode and fill count, and issues loader write strobes.
module ram_loader_fsm
    import sap_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count,
    output logic              load_we,
    output logic [ADDR_W-1:0] load_addr,
    output logic              run
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'((1 << ADDR_W) - 1);

    state_t            r_state;
    logic              r_prog_ready;
    logic              r_prog_done;
    logic [ADDR_W:0]   r_prog_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_prog_ready <= 1'b0;
            r_prog_done  <= 1'b0;
            r_prog_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (prog_mode) begin
                        r_state      <= LOAD;
                        r_prog_ready <= 1'b1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                LOAD: begin
                    if (prog_valid) begin
                        r_prog_count <= r_prog_count + 1'b1;
                        if (r_prog_count == LAST_IDX) begin
                            r_prog_done <= 1'b1;
                        end
                    end
                    // A byte accepted on the cycle prog_mode drops is still written above.
                    if (!prog_mode) begin
                        r_state      <= RUN;
                        r_prog_ready <= 1'b0;
                    end else if (prog_valid && r_prog_count == LAST_IDX) begin
                        r_state      <= DONE;
                        r_prog_ready <= 1'b0;
                    end
                end
                DONE: begin
                    if (!prog_mode) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (prog_mode) begin
                        r_state      <= LOAD;
                        r_prog_ready <= 1'b1;
                        r_prog_done  <= 1'b0;
                        r_prog_count <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign prog_ready = r_prog_ready;
    assign prog_done  = r_prog_done;
    assign prog_count = r_prog_count;
    assign load_we    = (r_state == LOAD) && prog_valid;
    assign load_addr  = r_prog_count[ADDR_W-1:0];
    assign run        = (r_state == RUN);

endmodule

// File: rtl/sap_ram.sv
// SAP-1 style RAM: 2**ADDR_W words, loader port for programming, bus port for RUN access.
module sap_ram
    import sap_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              ram_en,
    input  logic              ram_load,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_load_we;
    logic [ADDR_W-1:0] w_load_addr;
    logic              w_run;
    logic              w_run_we;

    ram_loader_fsm #(
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_count (prog_count),
        .load_we    (w_load_we),
        .load_addr  (w_load_addr),
        .run        (w_run)
    );

    // Read has priority: a simultaneous ram_en suppresses the RUN write.
    assign w_run_we = w_run && ram_load && !ram_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_load_we) begin
            r_mem[w_load_addr] <= prog_data;
        end else if (w_run_we) begin
            r_mem[address] <= bus_in;
        end
    end

    assign bus_oe  = w_run && ram_en;
    assign bus_out = bus_oe ? r_mem[address] : '0;

endmodule

// File: tb/tb_sap_ram.sv
// Directed bench for sap_ram: loading, RUN reads/writes, partial loads and resets.
module tb_sap_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] address;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       ram_en;
    logic       ram_load;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic       prog_done;
    logic [4:0] prog_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_mem [16];

    always #5 clk = ~clk;

    sap_ram dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .ram_en     (ram_en),
        .ram_load   (ram_load),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_count (prog_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; address = 4'h3; bus_in = 8'h00; ram_en = 1'b1; ram_load = 1'b0;
        prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        tick(); tick();
        checks++;
        if (prog_count !== 5'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", prog_count);
        end
        checks++;
        if ({prog_ready, prog_done, bus_oe} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {prog_ready, prog_done, bus_oe});
        end
        checks++;
        if (bus_out !== 8'h00) begin
            errors++; $display("FAIL reset_bus_out got %h want 00", bus_out);
        end
        ram_en = 1'b0;
    endtask

    task automatic test_load();
        rst = 1'b1; prog_mode = 1'b1;
        tick();
        checks++;
        if ({prog_ready, prog_count} !== {1'b1, 5'd0}) begin
            errors++; $display("FAIL load_enter got rdy=%b cnt=%0d want rdy=1 cnt=0",
                               prog_ready, prog_count);
        end
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1; prog_data = 8'(i); exp_mem[i] = 8'(i);
            tick();
            checks++;
            if (prog_count !== 5'(i + 1)) begin
                errors++; $display("FAIL load_count got %0d want %0d", prog_count, i + 1);
            end
            if (i == 14) begin
                checks++;
                if (prog_done !== 1'b0) begin
                    errors++; $display("FAIL load_early_done got %b want 0", prog_done);
                end
            end
        end
        checks++;
        if ({prog_done, prog_ready} !== 2'b10) begin
            errors++; $display("FAIL load_done got done/rdy=%b want 10", {prog_done, prog_ready});
        end
        prog_data = 8'hEE;
        tick();
        checks++;
        if ({prog_count, prog_done, prog_ready} !== {5'd16, 2'b10}) begin
            errors++; $display("FAIL done_ignores_valid got cnt=%0d done/rdy=%b want 16 10",
                               prog_count, {prog_done, prog_ready});
        end
        prog_valid = 1'b0;
    endtask

    task automatic test_readback();
        prog_mode = 1'b0;
        tick();
        ram_en = 1'b1; address = 4'h6;
        #1;
        checks++;
        if ({bus_oe, bus_out} !== {1'b1, 8'h06}) begin
            errors++; $display("FAIL readback got oe=%b data=%h want 1 06", bus_oe, bus_out);
        end
        ram_en = 1'b0;
        #1;
        checks++;
        if ({bus_oe, bus_out} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL readback_idle got oe=%b data=%h want 0 00", bus_oe, bus_out);
        end
    endtask

    task automatic test_run_write();
        ram_load = 1'b1; address = 4'hC; bus_in = 8'hA5; exp_mem[12] = 8'hA5;
        tick();
        ram_load = 1'b0; ram_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            address = 4'(i);
            #1;
            checks++;
            if (bus_out !== exp_mem[i]) begin
                errors++; $display("FAIL run_write_word%0d got %h want %h", i, bus_out, exp_mem[i]);
            end
        end
        ram_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        ram_en = 1'b1; ram_load = 1'b1; address = 4'hB; bus_in = 8'hFF;
        #1;
        checks++;
        if (bus_out !== 8'h0B) begin
            errors++; $display("FAIL simul_read got %h want 0b", bus_out);
        end
        tick();
        ram_load = 1'b0;
        #1;
        checks++;
        if (bus_out !== 8'h0B) begin
            errors++; $display("FAIL simul_write_suppressed got %h want 0b", bus_out);
        end
        ram_en = 1'b0;
    endtask

    task automatic test_partial();
        prog_mode = 1'b1;
        tick();
        checks++;
        if ({prog_count, prog_done, prog_ready} !== {5'd0, 2'b01}) begin
            errors++; $display("FAIL reenter_clear got cnt=%0d done/rdy=%b want 0 01",
                               prog_count, {prog_done, prog_ready});
        end
        // Bus requests during LOAD must neither drive the bus nor write.
        ram_en = 1'b1; ram_load = 1'b1; address = 4'h7; bus_in = 8'h77;
        for (int i = 0; i < 5; i++) begin
            prog_valid = 1'b1; prog_data = 8'(8'h50 + i); exp_mem[i] = 8'(8'h50 + i);
            #1;
            checks++;
            if ({bus_oe, bus_out} !== 9'h000) begin
                errors++; $display("FAIL load_bus_quiet got oe=%b data=%h want 0 00", bus_oe, bus_out);
            end
            tick();
        end
        ram_load = 1'b0; ram_en = 1'b0; prog_valid = 1'b0; prog_mode = 1'b0;
        tick();
        checks++;
        if (prog_count !== 5'd5) begin
            errors++; $display("FAIL partial_count got %0d want 5", prog_count);
        end
        prog_mode = 1'b1;
        tick();
        checks++;
        if (prog_count !== 5'd0) begin
            errors++; $display("FAIL partial_reenter got %0d want 0", prog_count);
        end
        prog_valid = 1'b1; prog_data = 8'h60; exp_mem[0] = 8'h60;
        tick();
        // Drop prog_mode alongside the second byte: it must still land.
        prog_data = 8'h61; exp_mem[1] = 8'h61; prog_mode = 1'b0;
        tick();
        prog_valid = 1'b0; ram_en = 1'b1;
        checks++;
        if (prog_count !== 5'd2) begin
            errors++; $display("FAIL drop_with_byte_count got %0d want 2", prog_count);
        end
        for (int i = 0; i < 8; i++) begin
            address = 4'(i);
            #1;
            checks++;
            if ({bus_oe, bus_out} !== {1'b1, exp_mem[i]}) begin
                errors++; $display("FAIL partial_word%0d got oe=%b data=%h want 1 %h",
                                   i, bus_oe, bus_out, exp_mem[i]);
            end
        end
        ram_en = 1'b0;
    endtask

    task automatic test_reset_midload();
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            prog_valid = 1'b1; prog_data = 8'(8'h90 + i);
            tick();
        end
        prog_valid = 1'b0;
        checks++;
        if (prog_count !== 5'd3) begin
            errors++; $display("FAIL midload_count got %0d want 3", prog_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({prog_count, prog_ready} !== 6'd0) begin
            errors++; $display("FAIL async_reset got cnt=%0d rdy=%b want 0 0", prog_count, prog_ready);
        end
        prog_mode = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        ram_en = 1'b1; address = 4'h1;
        #1;
        checks++;
        if ({bus_oe, bus_out} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL reset_cleared_a1 got oe=%b data=%h want 1 00", bus_oe, bus_out);
        end
        address = 4'hC;
        #1;
        checks++;
        if (bus_out !== 8'h00) begin
            errors++; $display("FAIL reset_cleared_ac got %h want 00", bus_out);
        end
        ram_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_readback();
        test_run_write();
        test_simultaneous();
        test_partial();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
